// File: rtl/reg_alu_pipe.sv
// reg_alu_pipe: two-stage register-file / ALU execution unit.
//
// Accepts one instruction per cycle under a valid/ready handshake. The
// instruction is either a load of din into rd, or an ALU op on two register
// operands. Operands are read and captured on the accept edge (stage 1). The
// result is computed and written back one edge later (stage 2). MUL is an
// iterative shift-add over DATA_W cycles and holds in_ready low meanwhile.
//
// Optional feature macro: RF_FWD_EN
//   defined   -> stage-1 operand reads bypass the pending stage-2 result
//   undefined -> operands come from the register array only (one bubble
//                needed between dependent instructions)
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   in_valid        instruction present
//   in_ready        block can accept (low while a MUL iterates)
//   load            1 = write din to rd, 0 = ALU op
//   din             load data
//   op              ALU opcode
//   rs1, rs2        source register addresses
//   rd              destination register address
//   out, out_rd     last written result and its destination
//   out_valid       one-cycle pulse per written result
//   out_zero        out == 0, registered with out
module reg_alu_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    input  logic [3:0]        op,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] out,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_valid,
    output logic              out_zero
);

    localparam int NREG  = 1 << ADDR_W;
    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [3:0] OP_PASS = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EX,
        S_MUL
    } state_t;

    // Stage-2 instruction register. During MUL, a holds the shifting
    // multiplicand and b the shifting multiplier.
    typedef struct packed {
        logic              load;
        logic [DATA_W-1:0] din;
        logic [3:0]        op;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } stage2_t;

    state_t            state, state_d;
    stage2_t           s2;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] regs [NREG];

    logic              accept;
    logic              mul_start;
    logic [DATA_W-1:0] ex_result;
    logic [DATA_W-1:0] opa, opb;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;

    assign in_ready  = (state != S_MUL);
    assign accept    = in_valid & in_ready;
    assign mul_start = accept & ~load & (op == OP_MUL);

    // Single-cycle result of the pending stage-2 instruction. MUL never
    // reaches this path; it is produced by the shift-add accumulator.
    always_comb begin
        ex_result = '0;
        if (s2.load) begin
            ex_result = s2.din;
        end else begin
            case (s2.op)
                OP_PASS: ex_result = s2.a;
                OP_ADD:  ex_result = s2.a + s2.b;
                OP_SUB:  ex_result = s2.a - s2.b;
                OP_AND:  ex_result = s2.a & s2.b;
                OP_OR:   ex_result = s2.a | s2.b;
                OP_XOR:  ex_result = s2.a ^ s2.b;
                OP_SLL:  ex_result = s2.a << s2.b[SH_W-1:0];
                OP_SRL:  ex_result = s2.a >> s2.b[SH_W-1:0];
                default: ex_result = '0;
            endcase
        end
    end

    // A result is written either by a pending single-cycle op or by a MUL
    // whose iteration count has run out.
    assign wr_en   = (state == S_EX) || ((state == S_MUL) && (cnt == '0));
    assign wr_data = (state == S_MUL) ? acc : ex_result;

    // Operand read. Only the EX state can have a result pending while a new
    // instruction is accepted, so that is the only bypass source.
    always_comb begin
        opa = regs[rs1];
        opb = regs[rs2];
`ifdef RF_FWD_EN
        if ((state == S_EX) && (s2.rd == rs1)) opa = ex_result;
        if ((state == S_EX) && (s2.rd == rs2)) opb = ex_result;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE, S_EX: begin
                if (accept)               state_d = mul_start ? S_MUL : S_EX;
                else                      state_d = S_IDLE;
            end
            S_MUL: begin
                if (cnt == '0)            state_d = S_IDLE;
            end
            default:                      state_d = S_IDLE;
        endcase
    end

    // Stage-2 capture, multiplier iteration and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2        <= '0;
            cnt       <= '0;
            acc       <= '0;
            out       <= '0;
            out_rd    <= '0;
            out_valid <= 1'b0;
            out_zero  <= 1'b1;
        end else begin
            out_valid <= wr_en;
            if (wr_en) begin
                out      <= wr_data;
                out_rd   <= s2.rd;
                out_zero <= (wr_data == '0);
            end
            if (accept) begin
                s2.load <= load;
                s2.din  <= din;
                s2.op   <= op;
                s2.rd   <= rd;
                s2.a    <= opa;
                s2.b    <= opb;
                if (mul_start) begin
                    cnt <= CNT_W'(DATA_W);
                    acc <= '0;
                end
            end else if ((state == S_MUL) && (cnt != '0)) begin
                // One multiplier bit per cycle; bits shifted past DATA_W
                // fall off, leaving the low half of the product.
                if (s2.b[0]) acc <= acc + s2.a;
                s2.a <= s2.a << 1;
                s2.b <= s2.b >> 1;
                cnt  <= cnt - CNT_W'(1);
            end
        end
    end

    // Register array
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[s2.rd] <= wr_data;
        end
    end

endmodule

// File: tb/tb_reg_alu_pipe.sv
// Self-checking bench for reg_alu_pipe: directed test-plan sequence followed
// by randomized instructions. The stimulus side keeps an architectural model
// of the register file and pushes the expected result, destination and
// result-edge number into a scoreboard queue; a monitor pops and compares on
// every out_valid.
module tb_reg_alu_pipe;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              load = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic [3:0]        op = '0;
    logic [ADDR_W-1:0] rs1 = '0;
    logic [ADDR_W-1:0] rs2 = '0;
    logic [ADDR_W-1:0] rd = '0;
    logic [DATA_W-1:0] out;
    logic [ADDR_W-1:0] out_rd;
    logic              out_valid;
    logic              out_zero;

    reg_alu_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .load(load), .din(din), .op(op), .rs1(rs1), .rs2(rs2), .rd(rd),
        .out(out), .out_rd(out_rd), .out_valid(out_valid), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;   // index of the most recent rising edge
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
        int                edge_no;
    } exp_t;
    exp_t sbq[$];

    // Architectural model state
    logic [DATA_W-1:0] mregs [1<<ADDR_W];
    int                prev_edge = -100;
    logic [ADDR_W-1:0] prev_rd = '0;
    logic [DATA_W-1:0] prev_old = '0;
    int                last_edge = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] alu(input logic [3:0] o,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
        logic [2*DATA_W-1:0] p;
        case (o)
            4'd0: return a;
            4'd1: return a + b;
            4'd2: return a - b;
            4'd3: return a & b;
            4'd4: return a | b;
            4'd5: return a ^ b;
            4'd6: return a << (b % DATA_W);
            4'd7: return a >> (b % DATA_W);
            4'd8: begin p = 64'(a) * 64'(b); return p[DATA_W-1:0]; end
            default: return '0;
        endcase
    endfunction

    // Without bypass, an instruction accepted on the edge right after the
    // producer sees the destination's value from before that producer.
    function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] r, input int e);
`ifndef RF_FWD_EN
        if (e == prev_edge + 1 && r == prev_rd) return prev_old;
`endif
        return mregs[r];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < (1 << ADDR_W); i++) mregs[i] = '0;
        prev_edge = -100;
        sbq.delete();
    endtask

    task automatic issue(input logic ld, input logic [DATA_W-1:0] d, input logic [3:0] o,
                         input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2,
                         input logic [ADDR_W-1:0] dst);
        int guard;
        int e;
        logic [DATA_W-1:0] va, vb, res;
        exp_t x;
        bit is_mul;
        @(negedge clk);
        in_valid = 1'b1; load = ld; din = d; op = o; rs1 = a1; rs2 = a2; rd = dst;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e = cyc;
        is_mul = !ld && (o == 4'd8);
        va = model_read(a1, e);
        vb = model_read(a2, e);
        res = ld ? d : alu(o, va, vb);
        x.rd = dst; x.data = res; x.edge_no = e + (is_mul ? DATA_W + 1 : 1);
        sbq.push_back(x);
        prev_edge = e; prev_rd = dst; prev_old = mregs[dst];
        mregs[dst] = res;
        last_edge = e;
    endtask

    // Monitor: compares every presented result against the scoreboard head
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sbq.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_out_valid: out=%0h out_rd=%0d with no result expected", out, out_rd);
            end else begin
                mon_e = sbq.pop_front();
                chk("out", 64'(out), 64'(mon_e.data));
                chk("out_rd", 64'(out_rd), 64'(mon_e.rd));
                chk("out_zero", 64'(out_zero), 64'(mon_e.data == '0));
                chk("out_edge", 64'(cyc), 64'(mon_e.edge_no));
            end
        end else if (rst_n && sbq.size() > 0 && sbq[0].edge_no < cyc) begin
            mon_e = sbq.pop_front();
            checks++; errors++;
            $display("FAIL missing_out_valid: result %0h for r%0d due at edge %0d not seen",
                     mon_e.data, mon_e.rd, mon_e.edge_no);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int k;
    logic              r_ld;
    logic [3:0]        r_op;
    logic [DATA_W-1:0] r_d;

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_out", 64'(out), 64'(0));
        chk("rst_out_rd", 64'(out_rd), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_zero", 64'(out_zero), 64'(1));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(1));

        // Loads, then ALU ops on them
        issue(1, 20, 0, 0, 0, 1);
        issue(1, 10, 0, 0, 0, 2);
        issue(1, 50, 0, 0, 0, 3);
        repeat (2) @(posedge clk);
        issue(0, 0, 4'd1, 1, 2, 5);    // ADD  -> 30
        issue(0, 0, 4'd2, 3, 2, 6);    // SUB  -> 40
        issue(0, 0, 4'd3, 1, 2, 7);    // AND  -> 0
        issue(0, 0, 4'd11, 1, 2, 8);   // undefined op -> 0
        // Dependency back-to-back, then with a bubble
        issue(1, 13, 0, 0, 0, 2);
        issue(0, 0, 4'd2, 3, 2, 9);
        issue(1, 13, 0, 0, 0, 2);
        @(posedge clk);
        issue(0, 0, 4'd2, 3, 2, 9);
        // Borrow wrap and shift-amount truncation
        issue(1, 10, 0, 0, 0, 2);
        @(posedge clk);
        issue(0, 0, 4'd2, 2, 1, 10);   // 10 - 20
        issue(1, 33, 0, 0, 0, 2);
        @(posedge clk);
        issue(0, 0, 4'd6, 1, 2, 11);   // 20 << (33 mod 32)
        // MUL with in_valid held through the stall
        issue(0, 0, 4'd8, 1, 3, 12);
        k = last_edge;
        issue(1, 99, 0, 0, 0, 13);
        chk("mul_next_accept_edge", 64'(last_edge - k), 64'(DATA_W + 2));
        // Pending EX result followed directly by MUL
        issue(1, 7, 0, 0, 0, 4);
        issue(0, 0, 4'd8, 4, 3, 14);

        // Reset in the middle of a MUL
        issue(0, 0, 4'd8, 1, 3, 15);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        chk("midmul_out", 64'(out), 64'(0));
        chk("midmul_out_rd", 64'(out_rd), 64'(0));
        chk("midmul_out_valid", 64'(out_valid), 64'(0));
        chk("midmul_out_zero", 64'(out_zero), 64'(1));
        chk("midmul_in_ready", 64'(in_ready), 64'(1));
        rst_n = 1'b1;
        issue(0, 0, 4'd0, 1, 1, 4);    // r1 cleared by reset
        issue(1, 7, 0, 0, 0, 1);
        issue(0, 0, 4'd1, 1, 1, 6);
        @(posedge clk);
        issue(0, 0, 4'd1, 1, 1, 6);

        // Randomized instructions
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
            r_ld = ($urandom_range(0, 2) == 0);
            r_op = 4'($urandom_range(0, 15));
            if (r_op == 4'd8 && $urandom_range(0, 3) != 0) r_op = 4'd2;
            r_d = ($urandom_range(0, 1) == 1) ? DATA_W'($urandom) : DATA_W'($urandom_range(0, 3));
            issue(r_ld, r_d, r_op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)));
        end

        repeat (DATA_W + 5) @(negedge clk);
        chk("scoreboard_drained", 64'(sbq.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
